// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation select for R-type and I-type arithmetic.
// Only R-type uses funct7[5] (sub); everything else defaults to add.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000:  alu_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b110:  alu_ctrl = ALU_OR;
        3'b111:  alu_ctrl = ALU_AND;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM over a shared req/ready memory, with access timeout.
// Optional feature macro PERF_CNT_EN enables cycle_cnt / instret_cnt counters.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 eq,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_ctrl,
  output logic [1:0]           result_src,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              set_illegal;
  logic              waiting, timeout_hit;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [2:0]        alu_dec;
  logic              unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  mc_alu_decoder u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (instr[30]),
    .alu_ctrl (alu_dec)
  );

  // Controls depend on mem_ready and eq within the same cycle, so they are decoded
  // combinationally from the registered state and forced low while reset is held.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    imm_src     = IMM_I;
    alu_ctrl    = ALU_ADD;
    result_src  = RES_ALUOUT;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXEC_R;
          OP_I:              state_next = EXEC_I;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_SYSTEM:         state_next = HALT;
          default: begin
            state_next  = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
        state_next = FETCH;
      end
      EXEC_R: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_ctrl   = alu_dec;
        state_next = ALUWB;
      end
      EXEC_I: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        alu_ctrl   = alu_dec;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_ctrl   = ALU_SUB;
        state_next = FETCH;
        if (funct3 == F3_BEQ) begin
          pc_write = eq;
        end else if (funct3 == F3_BNE) begin
          pc_write = ~eq;
        end else begin
          state_next  = HALT;
          set_illegal = 1'b1;
        end
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        imm_src    = IMM_J;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = HALT;
    endcase
    if (!rst) begin
      {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write} = '0;
      {alu_src_a, alu_src_b, imm_src, alu_ctrl, result_src}     = '0;
    end
  end

  assign waiting     = mem_req & ~mem_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // The wait counter only runs during a stalled access, so it restarts with every access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FETCH;
      wait_cnt      <= '0;
      halted        <= 1'b0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      if (timeout_hit) begin
        state     <= HALT;
        halted    <= 1'b1;
        bus_error <= 1'b1;
      end else begin
        state <= state_next;
        if (state_next == HALT) halted <= 1'b1;
        if (set_illegal) illegal_instr <= 1'b1;
      end
      if (waiting) wait_cnt <= wait_cnt + WAIT_W'(1);
      else         wait_cnt <= '0;
    end
  end

`ifdef PERF_CNT_EN
  logic retire;

  // Every return to FETCH from another state marks one completed instruction.
  assign retire = (state_next == FETCH) && (state != FETCH) && !timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != HALT) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors, timeout,
// illegal opcodes, async reset and (with PERF_CNT_EN) the performance counters.
module tb_multicycle_controller;

  logic        clk, rst;
  logic [31:0] instr;
  logic        eq, mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_ctrl;
  logic        halted, illegal_instr, bus_error;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [16:0] ctrl;

  int checksTotal  = 0;
  int checksPassed = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .halted(halted), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req, we, adr, irw, pcw, rw, srcA, srcB, imm, alu, res}
  assign ctrl = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, imm_src, alu_ctrl, result_src};

  localparam logic [16:0] V_FETCH   = 17'b1_0_0_1_1_0_00_10_00_000_10;
  localparam logic [16:0] V_WAIT_F  = 17'b1_0_0_0_0_0_00_00_00_000_00;
  localparam logic [16:0] V_WAIT_M  = 17'b1_0_1_0_0_0_00_00_00_000_00;
  localparam logic [16:0] V_DECODE  = 17'b0_0_0_0_0_0_01_01_10_000_00;
  localparam logic [16:0] V_EX_ADD  = 17'b0_0_0_0_0_0_10_00_00_000_00;
  localparam logic [16:0] V_EX_SUB  = 17'b0_0_0_0_0_0_10_00_00_001_00;
  localparam logic [16:0] V_EX_ORI  = 17'b0_0_0_0_0_0_10_01_00_011_00;
  localparam logic [16:0] V_EX_ADDI = 17'b0_0_0_0_0_0_10_01_00_000_00;
  localparam logic [16:0] V_ALUWB   = 17'b0_0_0_0_0_1_00_00_00_000_00;
  localparam logic [16:0] V_MA_LD   = 17'b0_0_0_0_0_0_10_01_00_000_00;
  localparam logic [16:0] V_MA_ST   = 17'b0_0_0_0_0_0_10_01_01_000_00;
  localparam logic [16:0] V_MEMRD   = 17'b1_0_1_0_0_0_00_00_00_000_00;
  localparam logic [16:0] V_MEMWB   = 17'b0_0_0_0_0_1_00_00_00_000_01;
  localparam logic [16:0] V_MEMWR   = 17'b1_1_1_0_0_0_00_00_00_000_00;
  localparam logic [16:0] V_BR_TK   = 17'b0_0_0_0_1_0_10_00_00_001_00;
  localparam logic [16:0] V_BR_NT   = 17'b0_0_0_0_0_0_10_00_00_001_00;
  localparam logic [16:0] V_JAL     = 17'b0_0_0_0_1_0_01_10_11_000_00;
  localparam logic [16:0] V_IDLE    = 17'b0;
  localparam logic [16:0] M_ALL     = 17'h1FFFF;
  localparam logic [16:0] M_HS      = 17'b1_1_1_1_1_1_00_00_00_000_00;

  localparam logic [31:0] I_ADD   = 32'h00208533;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_ORI   = 32'h0030E293;
  localparam logic [31:0] I_ADDI  = 32'h00100513;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BNE   = 32'hFE209CE3;
  localparam logic [31:0] I_BLT   = 32'h00004063;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_ECALL = 32'h00000073;

`ifdef PERF_CNT_EN
  localparam logic [31:0] EXP_INSTRET = 32'd10;
  localparam logic [31:0] EXP_CYCLES  = 32'd40;
`else
  localparam logic [31:0] EXP_INSTRET = 32'd0;
  localparam logic [31:0] EXP_CYCLES  = 32'd0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Drives one cycle of inputs, checks controls mid-cycle, then advances past the edge.
  task automatic applyStimulus(input string tag, input logic [31:0] i, input logic e,
                               input logic rdy, input logic [16:0] expv,
                               input logic [16:0] mask);
    instr = i; eq = e; mem_ready = rdy;
    @(negedge clk);
    checkOutput(tag, 32'(ctrl & mask), 32'(expv & mask));
    @(posedge clk); #1;
  endtask

  task automatic resetDut();
    rst = 1'b0; instr = '0; eq = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; instr = '0; eq = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", 32'(ctrl), 32'd0);
    checkOutput("reset_flags", 32'({halted, illegal_instr, bus_error}), 32'd0);
    checkOutput("reset_cycle_cnt", cycle_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // add: reg_write lands in cycle 4; FETCH ignores the stale IR opcode
    applyStimulus("add_fetch",  32'h0, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("add_decode", I_ADD, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("add_exec",   I_ADD, 1'b0, 1'b0, V_EX_ADD, M_ALL);
    applyStimulus("add_wb",     I_ADD, 1'b0, 1'b0, V_ALUWB,  M_ALL);
    applyStimulus("sub_fetch",  I_ADD, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("sub_decode", I_SUB, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("sub_exec",   I_SUB, 1'b0, 1'b0, V_EX_SUB, M_ALL);
    applyStimulus("sub_wb",     I_SUB, 1'b0, 1'b0, V_ALUWB,  M_ALL);
    applyStimulus("ori_fetch",  I_SUB, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("ori_decode", I_ORI, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("ori_exec",   I_ORI, 1'b0, 1'b0, V_EX_ORI, M_ALL);
    applyStimulus("ori_wb",     I_ORI, 1'b0, 1'b0, V_ALUWB,  M_ALL);

    // lw with three stalled MEMRD cycles; stray mem_ready in DECODE is ignored
    applyStimulus("lw_fetch",   I_ORI, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("lw_decode",  I_LW,  1'b0, 1'b1, V_DECODE, M_ALL);
    applyStimulus("lw_memadr",  I_LW,  1'b0, 1'b0, V_MA_LD,  M_ALL);
    for (int k = 0; k < 3; k++)
      applyStimulus("lw_memrd_wait", I_LW, 1'b0, 1'b0, V_WAIT_M, M_HS);
    applyStimulus("lw_memrd",   I_LW,  1'b0, 1'b1, V_MEMRD,  M_ALL);
    applyStimulus("lw_memwb",   I_LW,  1'b0, 1'b0, V_MEMWB,  M_ALL);

    applyStimulus("sw_fetch",   I_LW,  1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("sw_decode",  I_SW,  1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("sw_memadr",  I_SW,  1'b0, 1'b0, V_MA_ST,  M_ALL);
    applyStimulus("sw_memwr",   I_SW,  1'b0, 1'b1, V_MEMWR,  M_ALL);

    // bne taken (eq=0) then not taken (eq=1), each three cycles
    applyStimulus("bne0_fetch",  I_SW,  1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("bne0_decode", I_BNE, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("bne0_branch", I_BNE, 1'b0, 1'b0, V_BR_TK,  M_ALL);
    applyStimulus("bne1_fetch",  I_BNE, 1'b1, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("bne1_decode", I_BNE, 1'b1, 1'b0, V_DECODE, M_ALL);
    applyStimulus("bne1_branch", I_BNE, 1'b1, 1'b0, V_BR_NT,  M_ALL);

    applyStimulus("jal_fetch",  I_BNE, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("jal_decode", I_JAL, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("jal_exec",   I_JAL, 1'b0, 1'b0, V_JAL,    M_ALL);
    applyStimulus("jal_wb",     I_JAL, 1'b0, 1'b0, V_ALUWB,  M_ALL);
    applyStimulus("next_fetch", I_JAL, 1'b0, 1'b1, V_FETCH,  M_ALL);
    checkOutput("no_flags_after_run", 32'({halted, illegal_instr, bus_error}), 32'd0);

    // 15 stalls on each access must not time out: counter restarts per access
    resetDut();
    for (int k = 0; k < 15; k++)
      applyStimulus("fetch_wait15", 32'h0, 1'b0, 1'b0, V_WAIT_F, M_HS);
    applyStimulus("fetch_late",  32'h0, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("late_decode", I_LW,  1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("late_memadr", I_LW,  1'b0, 1'b0, V_MA_LD,  M_ALL);
    for (int k = 0; k < 15; k++)
      applyStimulus("memrd_wait15", I_LW, 1'b0, 1'b0, V_WAIT_M, M_HS);
    applyStimulus("memrd_late",  I_LW,  1'b0, 1'b1, V_MEMRD,  M_ALL);
    applyStimulus("late_memwb",  I_LW,  1'b0, 1'b0, V_MEMWB,  M_ALL);
    checkOutput("no_bus_error_15", 32'({halted, bus_error}), 32'd0);

    // 16 stalls: HALT with bus_error, request dropped, stays halted
    resetDut();
    for (int k = 0; k < 16; k++)
      applyStimulus("fetch_wait16", 32'h0, 1'b0, 1'b0, V_WAIT_F, M_HS);
    applyStimulus("timeout_halt", 32'h0, 1'b0, 1'b0, V_IDLE, M_ALL);
    checkOutput("timeout_flags", 32'({halted, illegal_instr, bus_error}), 32'b101);
    applyStimulus("timeout_stays", 32'h0, 1'b0, 1'b1, V_IDLE, M_ALL);

    // unsupported opcode
    resetDut();
    applyStimulus("ill_fetch",  32'h0, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("ill_decode", 32'h0, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("ill_halt",   32'h0, 1'b0, 1'b1, V_IDLE,   M_ALL);
    checkOutput("ill_flags", 32'({halted, illegal_instr, bus_error}), 32'b110);

    // ecall halts without flagging illegal
    resetDut();
    applyStimulus("ecall_fetch",  32'h0,   1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("ecall_decode", I_ECALL, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("ecall_halt",   I_ECALL, 1'b0, 1'b1, V_IDLE,   M_ALL);
    checkOutput("ecall_flags", 32'({halted, illegal_instr, bus_error}), 32'b100);

    // unsupported branch funct3
    resetDut();
    applyStimulus("blt_fetch",  32'h0, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("blt_decode", I_BLT, 1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("blt_branch", I_BLT, 1'b1, 1'b0, V_BR_NT,  M_ALL);
    applyStimulus("blt_halt",   I_BLT, 1'b0, 1'b1, V_IDLE,   M_ALL);
    checkOutput("blt_flags", 32'({halted, illegal_instr, bus_error}), 32'b110);

    // async reset in the middle of a stalled load
    resetDut();
    applyStimulus("rst_fetch",  32'h0, 1'b0, 1'b1, V_FETCH,  M_ALL);
    applyStimulus("rst_decode", I_LW,  1'b0, 1'b0, V_DECODE, M_ALL);
    applyStimulus("rst_memadr", I_LW,  1'b0, 1'b0, V_MA_LD,  M_ALL);
    applyStimulus("rst_memrd",  I_LW,  1'b0, 1'b0, V_WAIT_M, M_HS);
    rst = 1'b0;
    #2;
    checkOutput("midrd_reset_ctrl", 32'(ctrl), 32'd0);
    checkOutput("midrd_reset_flags", 32'({halted, illegal_instr, bus_error}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus("post_reset_fetch", 32'h0, 1'b0, 1'b1, V_FETCH, M_ALL);

    // ten addi instructions at four cycles each
    resetDut();
    for (int k = 0; k < 10; k++) begin
      applyStimulus("loop_fetch",  I_ADDI, 1'b0, 1'b1, V_FETCH,   M_ALL);
      applyStimulus("loop_decode", I_ADDI, 1'b0, 1'b0, V_DECODE,  M_ALL);
      applyStimulus("loop_exec",   I_ADDI, 1'b0, 1'b0, V_EX_ADDI, M_ALL);
      applyStimulus("loop_wb",     I_ADDI, 1'b0, 1'b0, V_ALUWB,   M_ALL);
    end
    checkOutput("instret_cnt", instret_cnt, EXP_INSTRET);
    checkOutput("cycle_cnt",   cycle_cnt,   EXP_CYCLES);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
